mmio_periph: RTL and testbench

- Peripheral unit directly downstream of the address decoder that flags memory-mapped accesses.
- Consumes the decoder's is_count / is_led strobes in the MEM stage.
- Holds a prescaled free-running cycle counter, read at 0x7f20, and a latched LED register, written at 0x7f00.
- Substitutes the counter value into load data on a counter read; drives the board LEDs.

---
 rtl/mmio_periph_pkg.sv | 14 +
 rtl/mmio_periph_if.sv | 28 ++
 rtl/mmio_periph_prescaler.sv | 32 +++
 rtl/mmio_periph.sv | 61 ++++++
 tb/tb_mmio_periph.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mmio_periph_pkg.sv
// Shared constants for the memory-mapped peripheral and the address decoder.
// The decoder and mmio_periph must agree on these addresses and widths.
// No logic lives here.
package mmio_periph_pkg;

  localparam logic [31:0] MMIO_LED_ADDR = 32'h0000_7f00;
  localparam logic [31:0] MMIO_CNT_ADDR = 32'h0000_7f20;
  localparam int          MMIO_LED_W    = 16;
  localparam int          MMIO_CNT_W    = 32;
  localparam int          MMIO_PRE_W    = 16;

  typedef logic [MMIO_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mmio_periph_if.sv
// MEM-stage side bus of the peripheral: strobes and data in, load data, LEDs and status out.
// The master drives the core-side strobes and data. The slave is the peripheral.
// Purely a signal bundle with no flow control.
interface mmio_periph_if #(
  parameter int LED_W = mmio_periph_pkg::MMIO_LED_W
) ();

  logic             cpu_en;
  logic             is_count;
  logic             is_led;
  logic [31:0]      wdata;
  logic [31:0]      mem_rdata;
  logic [31:0]      rdata_out;
  logic [LED_W-1:0] led;
  logic [31:0]      cnt_dbg;
  logic             cnt_ovf;

  modport master (
    output cpu_en, is_count, is_led, wdata, mem_rdata,
    input  rdata_out, led, cnt_dbg, cnt_ovf
  );

  modport slave (
    input  cpu_en, is_count, is_led, wdata, mem_rdata,
    output rdata_out, led, cnt_dbg, cnt_ovf
  );

endinterface

// File: rtl/mmio_periph_prescaler.sv
// Prescaler: tick pulses once every DIV enabled cycles.
// Tick is combinational in the same cycle that pre wraps.
// When en is low, pre holds its value and tick stays 0.
module mmio_prescaler
  import mmio_periph_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [MMIO_PRE_W-1:0] PRE_MAX = MMIO_PRE_W'(DIV - 1);

  logic [MMIO_PRE_W-1:0] r_pre;
  logic                  w_wrap;

  assign w_wrap = (r_pre == PRE_MAX);
  assign tick   = en & w_wrap;

  // Advance the phase counter on enabled cycles and wrap at DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_wrap ? '0 : r_pre + MMIO_PRE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_periph.sv
// Cycle counter at 0x7f20 and LED register at 0x7f00, placed downstream of the address decoder.
// Counter reads go through a zero-latency combinational load-data mux. LED writes appear one cycle later.
// This block never stalls. A write is committed only on a cycle with cpu_en high.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int LED_W = MMIO_LED_W,
  parameter int DIV   = 1
) (
  input  logic          clk,
  input  logic          rst,
  mmio_periph_if.slave  bus
);

  cnt_t             r_cnt;
  logic [LED_W-1:0] r_led;
  logic             r_ovf;
  logic             w_tick;
  logic             w_unused_wdata;

  mmio_prescaler #(
    .DIV (DIV)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.cpu_en),
    .tick (w_tick)
  );

  // Free-running counter. The wrap past all-ones latches the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + cnt_t'(1);
      if (r_cnt == '1) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // LED register. A stalled store (cpu_en low) re-presents later, so it is written only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (bus.is_led && bus.cpu_en) begin
      r_led <= bus.wdata[LED_W-1:0];
    end
  end

  // A counter read returns the pre-increment register value, even when a tick lands in the same cycle.
  assign bus.rdata_out = bus.is_count ? r_cnt : bus.mem_rdata;
  assign bus.led       = r_led;
  assign bus.cnt_dbg   = r_cnt;
  assign bus.cnt_ovf   = r_ovf;

  // The upper store bits have no destination.
  assign w_unused_wdata = ^bus.wdata;

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph with DIV=1 and DIV=4 instances sharing one stimulus stream.
// The reference model counts enabled cycles and derives the counter value arithmetically.
// The driver pushes expectations, and a negedge monitor pops them and compares.
module tb_mmio_periph;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        t_en  = 1'b0;
  logic        t_isc = 1'b0;
  logic        t_isl = 1'b0;
  logic [31:0] t_wd  = '0;
  logic [31:0] t_mr  = '0;

  mmio_periph_if #(.LED_W(16)) if1 ();
  mmio_periph_if #(.LED_W(16)) if4 ();

  assign if1.cpu_en    = t_en;
  assign if1.is_count  = t_isc;
  assign if1.is_led    = t_isl;
  assign if1.wdata     = t_wd;
  assign if1.mem_rdata = t_mr;
  assign if4.cpu_en    = t_en;
  assign if4.is_count  = t_isc;
  assign if4.is_led    = t_isl;
  assign if4.wdata     = t_wd;
  assign if4.mem_rdata = t_mr;

  mmio_periph #(.LED_W(16), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  mmio_periph #(.LED_W(16), .DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd4;
    logic [31:0] cnt1;
    logic [31:0] cnt4;
    logic [15:0] led;
    logic        ovf1;
    logic        ovf4;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the count of enabled cycles since reset, plus an offset introduced by a forced preload.
  longint      m_ticks = 0;
  longint      m_off1  = 0;
  longint      m_off4  = 0;
  logic [15:0] m_led   = '0;

  function automatic longint m_full(input longint off, input int div);
    return off + (m_ticks / div);
  endfunction

  function automatic logic [31:0] m_cnt(input longint off, input int div);
    return 32'(m_full(off, div));
  endfunction

  function automatic logic m_ovf(input longint off, input int div);
    return m_full(off, div) >= 64'sh1_0000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle of stimulus. Optionally pulse reset, or preload both counters to 0xFFFF_FFFE.
  task automatic cyc(input logic en, input logic isc, input logic isl,
                     input logic [31:0] wd, input logic [31:0] mr,
                     input logic rs, input logic frc);
    exp_t e;
    @(posedge clk);
    #1;
    t_en = en; t_isc = isc; t_isl = isl; t_wd = wd; t_mr = mr;
    rst = rs;
    if (rs) begin
      m_ticks = 0; m_off1 = 0; m_off4 = 0; m_led = '0;
    end
    if (frc) begin
      force dut1.r_cnt = 32'hFFFF_FFFE;
      force dut4.r_cnt = 32'hFFFF_FFFE;
      #1;
      release dut1.r_cnt;
      release dut4.r_cnt;
      m_off1 = 64'sh0_FFFF_FFFE - (m_ticks / 1);
      m_off4 = 64'sh0_FFFF_FFFE - (m_ticks / 4);
    end
    e.cnt1 = m_cnt(m_off1, 1);
    e.cnt4 = m_cnt(m_off4, 4);
    e.rd1  = isc ? e.cnt1 : mr;
    e.rd4  = isc ? e.cnt4 : mr;
    e.led  = m_led;
    e.ovf1 = m_ovf(m_off1, 1);
    e.ovf4 = m_ovf(m_off4, 4);
    sb.push_back(e);
    if (!rs) begin
      if (en) m_ticks++;
      if (en && isl) m_led = wd[15:0];
    end
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata1", if1.rdata_out, e.rd1);
        chk("rdata4", if4.rdata_out, e.rd4);
        chk("cnt1",   if1.cnt_dbg,   e.cnt1);
        chk("cnt4",   if4.cnt_dbg,   e.cnt4);
        chk("led1",   {16'h0, if1.led}, {16'h0, e.led});
        chk("led4",   {16'h0, if4.led}, {16'h0, e.led});
        chk("ovf1",   {31'h0, if1.cnt_ovf}, {31'h0, e.ovf1});
        chk("ovf4",   {31'h0, if4.cnt_ovf}, {31'h0, e.ovf4});
      end
    end
  end

  initial begin
    // Reset state.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // Ten enabled cycles, then a counter read and a plain load.
    run(10, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    // Prescaler: 12 enabled, 5 paused, 4 enabled.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    run(12, 1'b1);
    run(5, 1'b0);
    run(4, 1'b1);
    run(1, 1'b0);
    // LED write with and without cpu_en.
    cyc(1'b1, 1'b0, 1'b1, 32'h1234_A5C3, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
    run(2, 1'b0);
    // Wrap: preload to 0xFFFF_FFFE, then keep running past the wrap.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    run(12, 1'b1);
    // Asynchronous reset with led=0x00FF and cnt=0x55, then counting resumes.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
    run(84, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0F0F, 32'h0, 1'b1, 1'b0);
    run(6, 1'b1);
    // Simultaneous read and write with cnt=7.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    run(7, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0001, 32'hCAFE_F00D, 1'b0, 1'b0);
    run(2, 1'b0);
    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom, $urandom, $urandom_range(0, 63) == 0, 1'b0);
    end
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
